secded_decoder_pipe: RTL and testbench
======================================

Name: secded_decoder_pipe

Overview:
- Parametrised, pipelined SECDED decoder. It is the receive-side companion and next generation of the team's fixed 72/64 encoder.
- Accepts a codeword on a valid/ready stream. Recomputes the syndrome and overall parity, corrects any single-bit error, flags double errors, and emits the data word two cycles later.
- Sits between memory/link read paths and consumers. Keeps saturating SEC/DED event counters and a sticky first-error syndrome for software scrubbing.

Parameters:
- DATA_W, 64, data word width (≥4).
- P_W, 7, Hamming check-bit count. Must be the minimal P with 2^P ≥ DATA_W+P+1; violation is an elaboration error.
- CODE_W, DATA_W+P_W+1, codeword width (72 at defaults). Derived; do not override.
- COUNT_W, 16, width of each event counter.

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous, active-high reset
- code_in  input  CODE_W  received codeword
- in_valid  input  1  code_in valid
- in_ready  output  1  block can accept code_in this cycle
- data_out  output  DATA_W  corrected data
- out_valid  output  1  data_out/flags valid
- out_ready  input  1  consumer accepts
- sec_flag  output  1  single error corrected (qualified by out_valid)
- ded_flag  output  1  uncorrectable error (qualified by out_valid)
- syndrome_out  output  P_W  syndrome of the current output word
- sec_count  output  COUNT_W  saturating count of SEC words delivered
- ded_count  output  COUNT_W  saturating count of DED words delivered
- first_err_syn  output  P_W+1  {valid bit, syndrome} of the first SEC/DED since clear
- cnt_clr  input  1  synchronous clear of counters and first_err_syn

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Codeword layout (must match the encoder):
  - Bit 0 = overall parity.
  - Bits at positions 2^k (k=0..P_W-1) = Hamming check bits.
  - All remaining positions 1..CODE_W-1 carry data bits in ascending order, data[0] at position 3.
- Stage 1 (on accept: in_valid && in_ready):
  - syn = XOR of the indices i ∈ [1, CODE_W-1] where code_in[i]=1 (P_W bits).
  - par = XOR of all CODE_W bits.
  - Register code_in, syn, par.
- Stage 2 classification:
  - syn=0, par=0: clean.
  - par=1, syn<CODE_W: SEC. Flip bit syn; syn=0 means the P0 bit, so data is unchanged.
  - par=0, syn≠0: DED. Data is passed uncorrected.
  - par=1, syn≥CODE_W: DED (aliased multi-bit error).
  - Extract data bits after correction. Register data_out, sec_flag, ded_flag, syndrome_out.
- Latency: exactly 2 cycles from accept to out_valid with no back-pressure.
- Throughput: 1 word/cycle.
- Handshake:
  - Stage 2 loads when !out_valid || out_ready.
  - Stage 1 loads when !s1_valid || stage 2 loads.
  - in_ready is that stage-1 load enable (combinational from out_ready; no path from in_valid).
  - out_valid must stay high and data_out/flags stable until out_ready.
- Counters:
  - Increment at the output handshake (out_valid && out_ready) on sec_flag / ded_flag.
  - Saturate at 2^COUNT_W-1 with no wrap.
  - first_err_syn captures {1, syndrome_out} on the first SEC or DED handshake while its valid bit is 0. It holds thereafter.
  - cnt_clr zeroes both counters and first_err_syn. Clear wins over a same-cycle event; that event is not counted.
- Reset (asynchronous, any cycle, including mid-stream):
  - Pipeline valids, out_valid, flags, syndrome_out, data_out, counters and first_err_syn go to 0.
  - In-flight words are discarded.
  - in_ready is 1 on the first cycle after reset deassertion.

Decomposition:
- Shared package secded_pkg:
  - Function returning P_W for a given DATA_W.
  - Function mapping data index → codeword position.
  - Function is_pow2.
  - Classification enum {CLEAN, SEC, DED}.
  - The encoder's next revision uses the same package.
- One sub-module, secded_syndrome_calc: combinational, produces syn and par from a CODE_W word. It is reusable by the encoder's check-bit generation.

Test Plan:
- Encode data 64'h0123_4567_89AB_CDEF (defaults), send clean -> data_out equals input 2 cycles after accept; sec_flag=0, ded_flag=0, syndrome_out=0.
- Same word with codeword bit 3 flipped -> data_out corrected; sec_flag=1, syndrome_out=3, sec_count=1, first_err_syn={1,7'd3}.
- Flip bits 5 and 9 -> ded_flag=1, syndrome_out=12, ded_count=1, data_out equals the raw extracted bits; then flip bit 0 only -> sec_flag=1, syndrome_out=0, data unchanged.
- Stream 10 back-to-back words with out_ready held 0 for cycles 3-6 -> in_ready drops within 2 words, no loss or duplication, in-order output, data_out stable while stalled.
- COUNT_W=4, inject 20 SEC words -> sec_count saturates at 15; pulse cnt_clr in the same cycle as a SEC handshake -> sec_count=0, first_err_syn=0.
- Assert rst with 2 words in flight -> out_valid=0 immediately; no stale output after release. Repeat the clean test with DATA_W=32 (P_W=6, CODE_W=39).

Source files
------------

// File: rtl/secded_pkg.sv
// secded_pkg: shared SECDED types and codeword-layout helpers for encoder and decoder
package secded_pkg;
  typedef enum logic [1:0] {CLEAN, SEC, DED} cls_e;
  function automatic bit is_pow2(input int x);
    return x > 0 && (x & (x - 1)) == 0;
  endfunction
  // minimal Hamming check-bit count with 2^p >= dw + p + 1
  function automatic int calc_pw(input int dw);
    int p = 0;
    for (int k = 1; k < 31; k++) if (p == 0 && (1 << k) >= dw + k + 1) p = k;
    return p;
  endfunction
  // codeword position of data bit idx: non-power-of-two positions from 3 upward
  function automatic int data_pos(input int idx);
    int n = 0;
    int r = 0;
    for (int p = 3; p < idx + 40; p++)
      if (!is_pow2(p)) begin
        if (n == idx) r = p;
        n++;
      end
    return r;
  endfunction
endpackage

// File: rtl/secded_syndrome_calc.sv
// secded_syndrome_calc: combinational Hamming syndrome and overall parity of a codeword
module secded_syndrome_calc import secded_pkg::*; #(
  parameter int CODE_W = 72,
  parameter int P_W    = 7
) (
  input  logic [CODE_W-1:0] code_i,
  output logic [P_W-1:0]    syn_o,
  output logic              par_o
);
  // XOR of the indices of every set bit; position 0 carries no index weight
  always_comb begin
    syn_o = '0;
    for (int i = 1; i < CODE_W; i++) syn_o ^= code_i[i] ? P_W'(i) : '0;
  end
  assign par_o = ^code_i;
endmodule

// File: rtl/secded_decoder_pipe.sv
// secded_decoder_pipe: two-stage SECDED decoder with stream handshake and error statistics
module secded_decoder_pipe import secded_pkg::*; #(
  parameter int DATA_W  = 64,
  parameter int P_W     = 7,
  parameter int CODE_W  = DATA_W + P_W + 1,
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [CODE_W-1:0]  code_in,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [DATA_W-1:0]  data_out,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               sec_flag,
  output logic               ded_flag,
  output logic [P_W-1:0]     syndrome_out,
  output logic [COUNT_W-1:0] sec_count,
  output logic [COUNT_W-1:0] ded_count,
  output logic [P_W:0]       first_err_syn,
  input  logic               cnt_clr
);
  if (DATA_W < 4 || P_W != calc_pw(DATA_W) || CODE_W != DATA_W + P_W + 1) begin : g_bad_params
    $error("secded_decoder_pipe: inconsistent DATA_W/P_W/CODE_W");
  end
  logic [P_W-1:0] syn_c;
  logic par_c;
  logic [DATA_W-1:0] raw_c, data_c;
  logic s1_valid_q, s1_par_q;
  logic [P_W-1:0] s1_syn_q;
  logic [DATA_W-1:0] s1_raw_q;
  logic out_valid_q, sec_q, ded_q;
  logic [DATA_W-1:0] data_q;
  logic [P_W-1:0] syn_q;
  logic [COUNT_W-1:0] sec_cnt_q, sec_cnt_d, ded_cnt_q, ded_cnt_d;
  logic [P_W:0] first_q, first_d;
  logic s1_load, s2_load, hs;
  cls_e cls;
  secded_syndrome_calc #(.CODE_W(CODE_W), .P_W(P_W)) u_syn (
    .code_i(code_in),
    .syn_o (syn_c),
    .par_o (par_c)
  );
  // only data positions are kept; check bits matter solely through syn/par
  for (genvar j = 0; j < DATA_W; j++) begin : g_data
    assign raw_c[j]  = code_in[data_pos(j)];
    assign data_c[j] = s1_raw_q[j] ^ (cls == SEC && int'(s1_syn_q) == data_pos(j));
  end
  assign s2_load  = !out_valid_q || out_ready;
  assign s1_load  = !s1_valid_q || s2_load;
  assign in_ready = s1_load;
  assign hs       = out_valid_q && out_ready;
  assign cls = (!s1_par_q && s1_syn_q == '0) ? CLEAN :
               (s1_par_q && int'(s1_syn_q) < CODE_W) ? SEC : DED;
  // stage 1: capture raw data bits with syndrome and parity
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_raw_q   <= '0;
      s1_syn_q   <= '0;
      s1_par_q   <= 1'b0;
    end else if (s1_load) begin
      s1_valid_q <= in_valid;
      s1_raw_q   <= raw_c;
      s1_syn_q   <= syn_c;
      s1_par_q   <= par_c;
    end
  // stage 2: corrected data and classification, held while the consumer stalls
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      out_valid_q <= 1'b0;
      data_q      <= '0;
      sec_q       <= 1'b0;
      ded_q       <= 1'b0;
      syn_q       <= '0;
    end else if (s2_load) begin
      out_valid_q <= s1_valid_q;
      data_q      <= data_c;
      sec_q       <= s1_valid_q && cls == SEC;
      ded_q       <= s1_valid_q && cls == DED;
      syn_q       <= s1_syn_q;
    end
  // statistics next state: clear beats a same-cycle event, counters saturate
  always_comb begin
    sec_cnt_d = cnt_clr ? '0 : (hs && sec_q && sec_cnt_q != '1) ? sec_cnt_q + COUNT_W'(1) : sec_cnt_q;
    ded_cnt_d = cnt_clr ? '0 : (hs && ded_q && ded_cnt_q != '1) ? ded_cnt_q + COUNT_W'(1) : ded_cnt_q;
    first_d   = cnt_clr ? '0 : (hs && (sec_q || ded_q) && !first_q[P_W]) ? {1'b1, syn_q} : first_q;
  end
  // statistics registers
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sec_cnt_q <= '0;
      ded_cnt_q <= '0;
      first_q   <= '0;
    end else begin
      sec_cnt_q <= sec_cnt_d;
      ded_cnt_q <= ded_cnt_d;
      first_q   <= first_d;
    end
  assign out_valid     = out_valid_q;
  assign data_out      = data_q;
  assign sec_flag      = sec_q;
  assign ded_flag      = ded_q;
  assign syndrome_out  = syn_q;
  assign sec_count     = sec_cnt_q;
  assign ded_count     = ded_cnt_q;
  assign first_err_syn = first_q;
endmodule

// File: tb/tb_secded_decoder_pipe.sv
// tb_secded_decoder_pipe: directed table-driven check of the SECDED decoder at 72/64 and 39/32
module tb_secded_decoder_pipe;
  localparam logic [63:0] D   = 64'h0123_4567_89AB_CDEF;
  localparam logic [31:0] D32 = 32'h89AB_CDEF;
  logic clk = 0, rst = 1;
  logic [71:0] code0 = '0;
  logic iv0 = 0, ir0, ov0, or0 = 1, sec0, ded0, clr0 = 0;
  logic [63:0] d0;
  logic [6:0] syn0;
  logic [15:0] sc0, dc0;
  logic [7:0] fe0;
  logic [38:0] code1 = '0;
  logic iv1 = 0, ir1, ov1, or1 = 1, sec1, ded1, clr1 = 0;
  logic [31:0] d1;
  logic [5:0] syn1;
  logic [3:0] sc1, dc1;
  logic [6:0] fe1;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  secded_decoder_pipe u0 (
    .clk(clk), .rst(rst), .code_in(code0), .in_valid(iv0), .in_ready(ir0),
    .data_out(d0), .out_valid(ov0), .out_ready(or0), .sec_flag(sec0), .ded_flag(ded0),
    .syndrome_out(syn0), .sec_count(sc0), .ded_count(dc0), .first_err_syn(fe0), .cnt_clr(clr0)
  );
  secded_decoder_pipe #(.DATA_W(32), .P_W(6), .COUNT_W(4)) u1 (
    .clk(clk), .rst(rst), .code_in(code1), .in_valid(iv1), .in_ready(ir1),
    .data_out(d1), .out_valid(ov1), .out_ready(or1), .sec_flag(sec1), .ded_flag(ded1),
    .syndrome_out(syn1), .sec_count(sc1), .ded_count(dc1), .first_err_syn(fe1), .cnt_clr(clr1)
  );
  task automatic chk(input string n, input logic [71:0] a, input logic [71:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", n, a, e);
    end
  endtask
  // reference encoder: data in non-power-of-two positions from 3, even-parity check bits, overall parity at 0
  function automatic logic [71:0] enc(input logic [63:0] d, input int dw, input int pw);
    logic [71:0] c;
    logic x;
    int n;
    int cw;
    c = '0;
    n = 0;
    cw = dw + pw + 1;
    for (int p = 3; p < cw; p++)
      if ((p & (p - 1)) != 0) begin
        c[p] = d[n];
        n++;
      end
    for (int k = 0; k < pw; k++) begin
      x = 1'b0;
      for (int i = 1; i < cw; i++) if (((i >> k) & 1) != 0) x ^= c[i];
      c[1 << k] = x;
    end
    c[0] = ^c;
    return c;
  endfunction
  task automatic xfer0(input logic [71:0] c, output logic [63:0] d, output logic s, output logic e,
                       output logic [6:0] y, output int lat);
    @(negedge clk);
    code0 = c; iv0 = 1; or0 = 1;
    @(negedge clk);
    iv0 = 0; lat = 1;
    while (!ov0 && lat < 20) begin @(negedge clk); lat++; end
    d = d0; s = sec0; e = ded0; y = syn0;
  endtask
  task automatic xfer1(input logic [71:0] c, output logic [31:0] d, output logic s, output logic e,
                       output logic [5:0] y, output int lat);
    @(negedge clk);
    code1 = c[38:0]; iv1 = 1; or1 = 1;
    @(negedge clk);
    iv1 = 0; lat = 1;
    while (!ov1 && lat < 20) begin @(negedge clk); lat++; end
    d = d1; s = sec1; e = ded1; y = syn1;
  endtask
  typedef struct {
    logic [71:0] flip;
    logic [63:0] d;
    logic s;
    logic e;
    logic [6:0] y;
  } vec_t;
  vec_t tv[8];
  initial begin
    #1_000_000;
    $display("FAIL global_timeout got=1 expected=0");
    $fatal(1, "timeout");
  end
  initial begin
    logic [63:0] rd;
    logic [31:0] rd1;
    logic rs, re, any;
    logic [6:0] ry;
    logic [5:0] ry1;
    logic [71:0] t;
    logic [63:0] sd[10];
    logic [63:0] hd;
    int lat, es, ee, tx, rx, cyc, stall_acc;
    bit saw_low, hv;
    tv[0] = '{72'd0, D, 1'b0, 1'b0, 7'd0};
    tv[1] = '{72'd1 << 3, D, 1'b1, 1'b0, 7'd3};
    tv[2] = '{(72'd1 << 5) | (72'd1 << 9), D ^ 64'h12, 1'b0, 1'b1, 7'd12};
    tv[3] = '{72'd1, D, 1'b1, 1'b0, 7'd0};
    tv[4] = '{72'd1 << 71, D, 1'b1, 1'b0, 7'd71};
    tv[5] = '{72'd1 << 64, D, 1'b1, 1'b0, 7'd64};
    tv[6] = '{(72'd1 << 3) | (72'd1 << 70), D ^ 64'h4000_0000_0000_0001, 1'b0, 1'b1, 7'd69};
    tv[7] = '{(72'd1 << 1) | (72'd1 << 8) | (72'd1 << 64), D, 1'b0, 1'b1, 7'd73};
    repeat (2) @(negedge clk);
    rst = 0;
    #1;
    chk("reset_out_valid", ov0, 0);
    chk("reset_in_ready", ir0, 1);
    chk("reset_sec_count", sc0, 0);
    chk("reset_first_err", fe0, 0);
    es = 0; ee = 0;
    for (int i = 0; i < 8; i++) begin
      xfer0(enc(D, 64, 7) ^ tv[i].flip, rd, rs, re, ry, lat);
      chk($sformatf("v%0d_latency", i), lat, 2);
      chk($sformatf("v%0d_data", i), rd, tv[i].d);
      chk($sformatf("v%0d_sec", i), rs, tv[i].s);
      chk($sformatf("v%0d_ded", i), re, tv[i].e);
      chk($sformatf("v%0d_syndrome", i), ry, tv[i].y);
      es += int'(tv[i].s); ee += int'(tv[i].e);
      if (i == 1) begin
        @(negedge clk);
        chk("first_sec_count", sc0, 1);
        chk("first_err_after_sec", fe0, 8'h83);
      end
    end
    @(negedge clk);
    chk("table_sec_count", sc0, es);
    chk("table_ded_count", dc0, ee);
    chk("table_first_err", fe0, 8'h83);
    for (int i = 0; i < 10; i++) sd[i] = D + 64'(i) * 64'h0001_0203_0405_0607;
    tx = 0; rx = 0; cyc = 0; stall_acc = 0; saw_low = 0; hv = 0; hd = '0;
    while (rx < 10 && cyc < 60) begin
      @(negedge clk);
      if (hv) begin
        chk("stall_valid_held", ov0, 1);
        chk("stall_data_held", d0, hd);
      end
      or0 = !(cyc >= 3 && cyc <= 6);
      iv0 = tx < 10;
      code0 = enc(sd[tx < 10 ? tx : 0], 64, 7);
      #1;
      if (!or0 && !ir0) saw_low = 1;
      if (iv0 && ir0) begin
        tx++;
        if (!or0) stall_acc++;
      end
      if (ov0 && or0) begin
        chk($sformatf("stream_data_%0d", rx), d0, sd[rx]);
        rx++;
      end
      hv = ov0 && !or0; hd = d0;
      cyc++;
    end
    iv0 = 0; or0 = 1;
    @(negedge clk);
    chk("stream_sent", tx, 10);
    chk("stream_received", rx, 10);
    chk("stream_ready_dropped", saw_low, 1);
    chk("stream_accepts_in_stall_le2", stall_acc <= 2, 1);
    chk("stream_no_extra", ov0, 0);
    xfer1(enc({32'h0, D32}, 32, 6), rd1, rs, re, ry1, lat);
    chk("w32_latency", lat, 2);
    chk("w32_data", rd1, D32);
    chk("w32_sec", rs, 0);
    chk("w32_ded", re, 0);
    chk("w32_syndrome", ry1, 0);
    t = enc({32'h0, D32}, 32, 6) ^ (72'd1 << 3);
    for (int i = 0; i < 20; i++) begin
      xfer1(t, rd1, rs, re, ry1, lat);
      if (i == 0) begin
        chk("w32_sec_data", rd1, D32);
        chk("w32_sec_flag", rs, 1);
      end
    end
    @(negedge clk);
    chk("sat_sec_count", sc1, 15);
    chk("sat_ded_count", dc1, 0);
    chk("sat_first_err", fe1, 7'h43);
    code1 = t[38:0]; iv1 = 1; or1 = 1;
    @(negedge clk);
    iv1 = 0; lat = 0;
    while (!ov1 && lat < 20) begin @(negedge clk); lat++; end
    chk("clr_word_sec", sec1, 1);
    clr1 = 1;
    @(negedge clk);
    clr1 = 0;
    chk("clr_sec_count", sc1, 0);
    chk("clr_first_err", fe1, 0);
    @(negedge clk);
    or0 = 0; iv0 = 1; code0 = enc(D, 64, 7);
    @(negedge clk);
    code0 = enc(D ^ 64'h1, 64, 7);
    @(negedge clk);
    iv0 = 0;
    #1;
    chk("pre_rst_out_valid", ov0, 1);
    rst = 1;
    #1;
    chk("rst_out_valid", ov0, 0);
    chk("rst_sec_count", sc0, 0);
    chk("rst_first_err", fe0, 0);
    @(negedge clk);
    rst = 0; or0 = 1;
    #1;
    chk("post_rst_in_ready", ir0, 1);
    any = 0;
    repeat (4) begin @(negedge clk); any |= ov0; end
    chk("post_rst_no_stale", any, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
